// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct
// values, ALU operation codes and datapath mux selects.
package mips_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEM_ADR = 4'd2,
    ST_MEM_RD  = 4'd3,
    ST_MEM_WB  = 4'd4,
    ST_MEM_WR  = 4'd5,
    ST_R_EX    = 4'd6,
    ST_R_WB    = 4'd7,
    ST_BEQ     = 4'd8,
    ST_JMP     = 4'd9,
    ST_I_EX    = 4'd10,
    ST_I_WB    = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_LUI = 4'b1000;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU operation and immediate-extension decode from FSM state and IR fields.
// Purely combinational, zero latency; no handshake.
module mips_alu_dec
  import mips_pkg::*;
(
  input  state_e      state,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [3:0]  alu_ctrl,
  output logic        ext_zero,
  output logic        funct_ok
);

  logic [3:0] r_ctrl;

  always_comb begin
    funct_ok = 1'b1;
    r_ctrl   = ALU_ADD;
    case (funct)
      FN_ADD:  r_ctrl = ALU_ADD;
      FN_SUB:  r_ctrl = ALU_SUB;
      FN_AND:  r_ctrl = ALU_AND;
      FN_OR:   r_ctrl = ALU_OR;
      FN_SLT:  r_ctrl = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    alu_ctrl = ALU_AND;
    ext_zero = 1'b0;
    case (state)
      ST_FETCH, ST_DECODE, ST_MEM_ADR: alu_ctrl = ALU_ADD;
      ST_R_EX:                         alu_ctrl = r_ctrl;
      ST_BEQ:                          alu_ctrl = ALU_SUB;
      // I_WB keeps the I_EX decode so the ALU result stays stable while it is written back
      ST_I_EX, ST_I_WB: begin
        case (opcode)
          OP_ORI: begin
            alu_ctrl = ALU_OR;
            ext_zero = 1'b1;
          end
          OP_LUI:  alu_ctrl = ALU_LUI;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: lw 5, sw/R/I 4, beq/j 3 cycles with memory ready.
// FETCH, MEM_RD and MEM_WR hold their strobes until mem_ready; other states never stall.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_HS = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             PcReSet,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             ir_wr,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_wr,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  localparam bit USE_READY = (MEM_HS != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             mem_ok, funct_ok, pc_write, branch, retire;

  assign mem_ok = mem_ready | ~USE_READY;

  mips_alu_dec u_alu_dec (
    .state    (state_q),
    .opcode   (opcode),
    .funct    (funct),
    .alu_ctrl (alu_ctrl),
    .ext_zero (ext_zero),
    .funct_ok (funct_ok)
  );

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REG;
    pc_src     = PCSRC_ALU;
    illegal    = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ok) begin
          ir_wr    = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = SRCB_BRANCH;
        case (opcode)
          OP_RTYPE: begin
            if (funct_ok) state_d = ST_R_EX;
            else begin
              illegal = 1'b1;
              state_d = ST_FETCH;
            end
          end
          OP_LW, OP_SW:              state_d = ST_MEM_ADR;
          OP_BEQ:                    state_d = ST_BEQ;
          OP_J:                      state_d = ST_JMP;
          OP_ADDI, OP_ORI, OP_LUI:   state_d = ST_I_EX;
          default: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ok) state_d = ST_MEM_WB;
      end
      ST_MEM_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ok) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_R_EX: begin
        alu_src_a = 1'b1;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_wr  = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_BEQ: begin
        alu_src_a = 1'b1;
        pc_src    = PCSRC_ALUOUT;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JMP: begin
        pc_src   = PCSRC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_I_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = ST_I_WB;
      end
      ST_I_WB: begin
        reg_wr  = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    pc_en     = pc_write | (branch & zero);
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

    // Reset aborts whatever is in flight: no strobe may reach the datapath this cycle
    if (PcReSet) begin
      pc_en   = 1'b0;
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      ir_wr   = 1'b0;
      reg_wr  = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (PcReSet) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed plus randomized bench for mips_mc_ctrl; expected behaviour comes from
// per-instruction phase lists and a per-phase output table built from the ISA rules.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        PcReSet;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic        pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr;
  logic        alu_src_a, ext_zero, illegal;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_ctrl, state;
  logic [31:0] instret;

  int errors = 0;
  int checks = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.MEM_HS(1), .CNT_W(32)) dut (
    .clk        (clk),
    .PcReSet    (PcReSet),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .ir_wr      (ir_wr),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_wr     (reg_wr),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .ext_zero   (ext_zero),
    .alu_ctrl   (alu_ctrl),
    .pc_src     (pc_src),
    .state      (state),
    .illegal    (illegal),
    .instret    (instret)
  );

  logic [18:0] obs_vec;
  logic [5:0]  obs_strobes;
  assign obs_vec = {pc_en, iord, mem_rd, mem_wr, ir_wr, reg_dst, mem_to_reg, reg_wr,
                    alu_src_a, alu_src_b, ext_zero, alu_ctrl, pc_src, illegal};
  assign obs_strobes = {pc_en, mem_rd, mem_wr, ir_wr, reg_wr, illegal};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000)
      return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    return op inside {6'b100011, 6'b101011, 6'b000100, 6'b000010,
                      6'b001000, 6'b001101, 6'b001111};
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b0010;
    endcase
  endfunction

  // Expected outputs for one cycle spent in phase s.
  function automatic logic [18:0] exp_out(input int s, input logic [5:0] op, input logic [5:0] fn,
                                          input logic rdy, input logic zb);
    logic pe, io, mr, mw, iw, rd, m2r, rw, sa, ez, il;
    logic [1:0] sb, ps;
    logic [3:0] ac;
    {pe, io, mr, mw, iw, rd, m2r, rw, sa, ez, il} = '0;
    sb = 2'b00; ps = 2'b00; ac = 4'b0000;
    case (s)
      0:  begin mr = 1; sb = 2'b01; ac = 4'b0010; iw = rdy; pe = rdy; end
      1:  begin sb = 2'b11; ac = 4'b0010; il = !is_legal(op, fn); end
      2:  begin sa = 1; sb = 2'b10; ac = 4'b0010; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mw = 1; io = 1; end
      6:  begin sa = 1; ac = r_alu(fn); end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ac = 4'b0110; ps = 2'b01; pe = zb; end
      9:  begin ps = 2'b10; pe = 1; end
      10, 11: begin
        if (s == 10) begin sa = 1; sb = 2'b10; end
        else rw = 1;
        if (op == 6'b001101) begin ac = 4'b0001; ez = 1; end
        else if (op == 6'b001111) ac = 4'b1000;
        else ac = 4'b0010;
      end
      default: ;
    endcase
    return {pe, io, mr, mw, iw, rd, m2r, rw, sa, sb, ez, ac, ps, il};
  endfunction

  // One clock in phase s: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input int s, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic zb);
    logic zv, rv;
    PcReSet = 1'b0;
    opcode  = op;
    funct   = fn;
    rv = (s == 0 || s == 3 || s == 5) ? rdy : 1'($urandom);
    zv = (s == 8) ? zb : 1'($urandom);
    mem_ready = rv;
    zero      = zv;
    @(negedge clk);
    chk($sformatf("state_ph%0d_op%0h", s, op), 64'(state), 64'(s));
    chk($sformatf("outs_ph%0d_op%0h", s, op), 64'(obs_vec), 64'(exp_out(s, op, fn, rv, zv)));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zb,
                           input int wf, input int wm);
    int path[$];
    int nw;
    path = {0, 1};
    if (is_legal(op, fn)) begin
      case (op)
        6'b100011: path = {path, 2, 3, 4};
        6'b101011: path = {path, 2, 5};
        6'b000100: path = {path, 8};
        6'b000010: path = {path, 9};
        6'b000000: path = {path, 6, 7};
        default:   path = {path, 10, 11};
      endcase
      model_cnt++;
    end
    for (int k = 0; k < path.size(); k++) begin
      nw = (path[k] == 0) ? wf : ((path[k] == 3 || path[k] == 5) ? wm : 0);
      for (int w = 0; w < nw; w++) step(path[k], op, fn, 1'b0, zb);
      step(path[k], op, fn, 1'b1, zb);
    end
    chk($sformatf("instret_op%0h", op), 64'(instret), 64'(model_cnt));
  endtask

  logic [5:0] ops_tab [11];
  logic [5:0] fns_tab [5];

  initial begin
    logic [5:0] rop, rfn;
    ops_tab = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08, 6'h0d, 6'h0f, 6'h00, 6'h3f};
    fns_tab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    PcReSet = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = '0; funct = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_state", 64'(state), 64'd0);
      chk("reset_strobes", 64'(obs_strobes), 64'd0);
      chk("reset_instret", 64'(instret), 64'd0);
      @(posedge clk); #1;
    end

    run_instr(6'b100011, 6'h00, 1'b0, 0, 0);       // lw
    run_instr(6'b101011, 6'h00, 1'b0, 0, 2);       // sw with two memory waits
    run_instr(6'b000100, 6'h00, 1'b1, 0, 0);       // beq taken
    run_instr(6'b000100, 6'h00, 1'b0, 0, 0);       // beq not taken
    run_instr(6'b000000, 6'b100000, 1'b0, 1, 0);   // add, fetch wait
    run_instr(6'b001101, 6'h00, 1'b0, 0, 0);       // ori
    run_instr(6'b001111, 6'h00, 1'b0, 0, 0);       // lui
    run_instr(6'b001000, 6'h00, 1'b0, 0, 0);       // addi
    run_instr(6'b000010, 6'h00, 1'b0, 0, 0);       // j
    for (int i = 1; i < 5; i++) run_instr(6'b000000, fns_tab[i], 1'b0, 0, 0);
    run_instr(6'b111111, 6'h00, 1'b0, 0, 0);       // illegal opcode
    run_instr(6'b000000, 6'b000000, 1'b0, 0, 0);   // illegal funct
    run_instr(6'b100011, 6'h00, 1'b0, 0, 3);       // lw with read waits

    // Reset while MEM_RD is stalled
    step(0, 6'b100011, 6'h00, 1'b1, 1'b0);
    step(1, 6'b100011, 6'h00, 1'b1, 1'b0);
    step(2, 6'b100011, 6'h00, 1'b1, 1'b0);
    step(3, 6'b100011, 6'h00, 1'b0, 1'b0);
    PcReSet = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    chk("midreset_strobes", 64'(obs_strobes), 64'd0);
    @(posedge clk); #1;
    model_cnt = 0;
    @(negedge clk);
    chk("midreset_state", 64'(state), 64'd0);
    chk("midreset_instret", 64'(instret), 64'd0);
    chk("midreset_reg_wr", 64'(reg_wr), 64'd0);
    @(posedge clk); #1;
    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      rop = ops_tab[$urandom_range(0, 10)];
      if (rop == 6'h3f) rop = 6'($urandom);
      rfn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns_tab[$urandom_range(0, 4)];
      run_instr(rop, rfn, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multicycle control FSM for the MIPS core. Sits between the instruction register and the datapath.
- Decodes opcode/funct and sequences fetch, decode, execute, memory and writeback. Drives every datapath enable and mux select.
- Supports a memory ready handshake so instruction/data memory may stall.
- Provides a retired-instruction counter and an illegal-opcode flag for bench observation.

Parameters:
- MEM_HS, 1, 1 = honour mem_ready; 0 = mem_ready is treated as constant 1.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- PcReSet  in  1  synchronous active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the access this cycle.
- pc_en  out  1  PC load = pc_write | (branch & zero).
- iord  out  1  0 = address from PC, 1 = address from ALUOut.
- mem_rd  out  1  memory read strobe.
- mem_wr  out  1  memory write strobe.
- ir_wr  out  1  IR load.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- reg_wr  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = const 4, 10 = ext(imm), 11 = sext(imm)<<2.
- ext_zero  out  1  1 = zero-extend imm (ori), 0 = sign-extend.
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 LUI (B<<16).
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- States and encoding: FETCH 0, DECODE 1, MEM_ADR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EX 6, R_WB 7, BEQ 8, JMP 9, I_EX 10, I_WB 11.
- Reset (PcReSet=1 at an edge): state ← FETCH, instret ← 0. While PcReSet is high, all strobes (pc_en, mem_rd, mem_wr, ir_wr, reg_wr) and illegal are forced to 0. The first fetch occurs in the first cycle with PcReSet low.
- Reset mid-operation aborts the instruction. No write strobe is asserted in the reset cycle.
- FETCH:
  - mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
  - ir_wr and pc_en are asserted only in the cycle mem_ready=1, then the FSM goes to DECODE. Otherwise it stays in FETCH with mem_rd held.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 000000 → R_EX
  - 100011 / 101011 → MEM_ADR
  - 000100 → BEQ
  - 000010 → JMP
  - 001000 / 001101 / 001111 → I_EX
  - other → FETCH, with illegal=1 for this cycle.
  - An R-type funct not in {100000, 100010, 100100, 100101, 101010} also pulses illegal and returns to FETCH.
- MEM_ADR: A + sext(imm), ADD. Goes to MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_rd=1, iord=1. Advances to MEM_WB on mem_ready, else holds.
- MEM_WB: reg_wr=1, reg_dst=0, mem_to_reg=1. → FETCH.
- MEM_WR: mem_wr=1, iord=1. Goes to FETCH on mem_ready, else holds with mem_wr asserted.
- R_EX: alu_src_a=1, alu_src_b=00, alu_ctrl from funct (add→ADD, sub→SUB, and→AND, or→OR, slt→SLT). → R_WB.
- R_WB: reg_wr=1, reg_dst=1, mem_to_reg=0. → FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_en=zero. → FETCH.
- JMP: pc_src=10, pc_en=1. → FETCH.
- I_EX: alu_src_a=1, alu_src_b=10.
  - addi: ADD, ext_zero=0.
  - ori: OR, ext_zero=1.
  - lui: LUI.
  - → I_WB.
- I_WB: reg_wr=1, reg_dst=0, mem_to_reg=0. ext_zero and alu_ctrl are held per opcode. → FETCH.
- instret increments by 1 on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BEQ, JMP or I_WB. It wraps modulo 2^CNT_W. Illegal returns do not count.
- Latency with mem_ready tied high: lw 5, sw 4, R 4, I-type 4, beq 3, j 3 cycles.
- Each memory wait cycle adds one cycle.
- Outputs not listed for a state are 0.

Decomposition:
- Package mips_pkg holds:
  - state localparams;
  - opcode/funct constants;
  - alu_ctrl codes;
  - alu_src_b and pc_src encodings.
- One sub-module, mips_alu_dec: combinational (state, opcode, funct) → alu_ctrl, ext_zero, funct_ok.
- The FSM, output decode and instret counter stay in mips_mc_ctrl.

Test Plan:
- Reset: PcReSet=1 for 3 cycles, then 0, mem_ready=1 → state=0, all strobes 0 while reset is high. First cycle after release: mem_rd=1. Next edge: state=1.
- lw (opcode 100011), mem_ready=1 → state sequence 0,1,2,3,4. reg_wr=1 with mem_to_reg=1 only in state 4. instret goes 0→1.
- sw with mem_ready low for 2 cycles in MEM_WR → mem_wr held 3 cycles, total 6 cycles. instret +1 only after mem_ready.
- beq with zero=1, then zero=0 → pc_en=1 in BEQ for the first and 0 for the second. pc_src=01 both times. 3 cycles each.
- R-type add, ori, lui → alu_ctrl 0010, then 0001 with ext_zero=1, then 1000. reg_dst=1 for add, 0 for ori and lui.
- Opcode 111111, and funct 000000 with opcode 0 → illegal=1 pulse in DECODE, back to FETCH, instret unchanged. PcReSet asserted during MEM_RD → next state=0, reg_wr never asserted.
